// File: rtl/reg_file.sv
// Register file with two architectural read ports, a debug read port, one write port,
// an effective-write counter and per-register "written since reset" flags.
module reg_file #(
   parameter  int unsigned WIDTH   = 32,
   parameter  int unsigned DEPTH   = 32,
   parameter  logic [31:0] CNT_RST = 32'h0000_0000,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [AW-1:0]    rs1_addr_i,
   input  logic [AW-1:0]    rs2_addr_i,
   output logic [WIDTH-1:0] rs1_data_o,
   output logic [WIDTH-1:0] rs2_data_o,
   input  logic             rd_we_i,
   input  logic [AW-1:0]    rd_addr_i,
   input  logic [WIDTH-1:0] rd_data_i,
   input  logic [AW-1:0]    dbg_addr_i,
   output logic [WIDTH-1:0] dbg_data_o,
   output logic [31:0]      wr_cnt_o,
   output logic [DEPTH-1:0] dirty_o
);

   // Register 0 has no storage; it reads as zero like any out-of-range address.
   logic [WIDTH-1:0] regs [1:DEPTH-1];
   logic             wr_eff;

   function automatic logic valid_addr(input logic [AW-1:0] a);
      return (a != '0) && (32'(a) < DEPTH);
   endfunction

   function automatic logic [WIDTH-1:0] rd_port(input logic [AW-1:0] a);
      logic [WIDTH-1:0] v;
      v = '0;
      if (valid_addr(a)) v = regs[a];
      return v;
   endfunction

   // Reads are purely combinational from stored state: no write-to-read bypass.
   always_comb begin
      rs1_data_o = rd_port(rs1_addr_i);
      rs2_data_o = rd_port(rs2_addr_i);
      dbg_data_o = rd_port(dbg_addr_i);
   end

   assign wr_eff = rd_we_i && valid_addr(rd_addr_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 1; i < DEPTH; i++) regs[AW'(i)] <= '0;
         wr_cnt_o <= CNT_RST;
         dirty_o  <= '0;
      end else if (wr_eff) begin
         regs[rd_addr_i]    <= rd_data_i;
         wr_cnt_o           <= wr_cnt_o + 32'd1;
         dirty_o[rd_addr_i] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Directed and model-checked bench for reg_file; a second instance with a shortened
// counter start and DEPTH=20 covers counter wrap and out-of-range addresses.
module tb_reg_file;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, we;
   logic [4:0]  rs1, rs2, rd, dbg;
   logic [31:0] wdata, rs1_d, rs2_d, dbg_d, cnt, dirty;

   logic        rst_w, we_w;
   logic [4:0]  rs1_w, rs2_w, rd_w, dbg_w;
   logic [31:0] wdata_w, rs1_dw, rs2_dw, dbg_dw, cnt_w;
   logic [19:0] dirty_w;

   int checks = 0;
   int errors = 0;

   reg_file #(.WIDTH(32), .DEPTH(32)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .rs1_addr_i(rs1), .rs2_addr_i(rs2),
      .rs1_data_o(rs1_d), .rs2_data_o(rs2_d),
      .rd_we_i(we), .rd_addr_i(rd), .rd_data_i(wdata),
      .dbg_addr_i(dbg), .dbg_data_o(dbg_d),
      .wr_cnt_o(cnt), .dirty_o(dirty)
   );

   reg_file #(.WIDTH(32), .DEPTH(20), .CNT_RST(32'hFFFF_FFFE)) u_wrap (
      .clk_i(clk), .rst_i(rst_w),
      .rs1_addr_i(rs1_w), .rs2_addr_i(rs2_w),
      .rs1_data_o(rs1_dw), .rs2_data_o(rs2_dw),
      .rd_we_i(we_w), .rd_addr_i(rd_w), .rd_data_i(wdata_w),
      .dbg_addr_i(dbg_w), .dbg_data_o(dbg_dw),
      .wr_cnt_o(cnt_w), .dirty_o(dirty_w)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] m [32];
   logic [31:0] mcnt, mdirty;

   initial begin
      rst = 1'b1; we = 1'b0; rd = '0; wdata = '0; rs1 = '0; rs2 = '0; dbg = '0;
      rst_w = 1'b1; we_w = 1'b0; rd_w = '0; wdata_w = '0; rs1_w = '0; rs2_w = '0; dbg_w = '0;
      tick();
      rst = 1'b0;
      rst_w = 1'b0;

      // Reset sweep on all three read ports.
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i); rs2 = 5'(31 - i); dbg = 5'(i);
         #1;
         chk($sformatf("rst_rs1[%0d]", i), rs1_d, 32'h0);
         chk($sformatf("rst_rs2[%0d]", 31 - i), rs2_d, 32'h0);
         chk($sformatf("rst_dbg[%0d]", i), dbg_d, 32'h0);
      end
      chk("rst_cnt", cnt, 32'h0);
      chk("rst_dirty", dirty, 32'h0);

      // Write x5 then read back.
      we = 1'b1; rd = 5'd5; wdata = 32'hDEADBEEF;
      tick();
      we = 1'b0; rs1 = 5'd5; #1;
      chk("x5_rd", rs1_d, 32'hDEADBEEF);
      chk("x5_cnt", cnt, 32'd1);
      chk("x5_dirty", dirty, 32'h0000_0020);

      // Write to x0 is discarded.
      we = 1'b1; rd = 5'd0; wdata = 32'h12345678;
      tick();
      we = 1'b0; rs1 = 5'd0; rs2 = 5'd0; dbg = 5'd0; #1;
      chk("x0_rs1", rs1_d, 32'h0);
      chk("x0_rs2", rs2_d, 32'h0);
      chk("x0_dbg", dbg_d, 32'h0);
      chk("x0_cnt", cnt, 32'd1);
      chk("x0_dirty", dirty, 32'h0000_0020);

      // Write enable low changes nothing.
      we = 1'b0; rd = 5'd5; wdata = 32'h0; rs1 = 5'd5;
      tick();
      chk("nowe_rd", rs1_d, 32'hDEADBEEF);
      chk("nowe_cnt", cnt, 32'd1);

      // Same-cycle read/write of x7.
      we = 1'b1; rd = 5'd7; wdata = 32'hA;
      tick();
      wdata = 32'hB; rs2 = 5'd7; #1;
      chk("rw_old", rs2_d, 32'hA);
      tick();
      we = 1'b0; #1;
      chk("rw_new", rs2_d, 32'hB);
      chk("rw_cnt", cnt, 32'd3);
      chk("rw_dirty", dirty, 32'h0000_00A0);

      // Mid-stream reset with a simultaneous write to x3.
      rst = 1'b1; we = 1'b1; rd = 5'd3; wdata = 32'hFF; rs1 = 5'd5; #1;
      chk("rst_pre_edge", rs1_d, 32'hDEADBEEF);
      tick();
      rst = 1'b0; we = 1'b0; rs1 = 5'd3; rs2 = 5'd5; dbg = 5'd7; #1;
      chk("rstw_x3", rs1_d, 32'h0);
      chk("rstw_x5", rs2_d, 32'h0);
      chk("rstw_x7", dbg_d, 32'h0);
      chk("rstw_cnt", cnt, 32'h0);
      chk("rstw_dirty", dirty, 32'h0);

      // Random traffic against a reference model.
      for (int i = 0; i < 32; i++) m[i] = '0;
      mcnt = '0;
      mdirty = '0;
      for (int n = 0; n < 300; n++) begin
         we    = 1'($urandom_range(0, 1));
         rd    = 5'($urandom_range(0, 31));
         wdata = $urandom;
         rs1   = 5'($urandom_range(0, 31));
         rs2   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         dbg   = 5'($urandom_range(0, 31));
         #1;
         chk($sformatf("rnd_rs1[%0d]", n), rs1_d, m[rs1]);
         chk($sformatf("rnd_rs2[%0d]", n), rs2_d, m[rs2]);
         chk($sformatf("rnd_dbg[%0d]", n), dbg_d, m[dbg]);
         tick();
         if (we && rd != 5'd0) begin
            m[rd] = wdata;
            mcnt = mcnt + 32'd1;
            mdirty[rd] = 1'b1;
         end
      end
      we = 1'b0; #1;
      chk("rnd_cnt", cnt, mcnt);
      chk("rnd_dirty", dirty, mdirty);

      // Counter wrap and out-of-range addresses on the DEPTH=20 instance.
      chk("wrap_rst_cnt", cnt_w, 32'hFFFF_FFFE);
      we_w = 1'b1; rd_w = 5'd4; wdata_w = 32'h11;
      tick();
      chk("wrap_cnt_max", cnt_w, 32'hFFFF_FFFF);
      rd_w = 5'd9; wdata_w = 32'h22;
      tick();
      chk("wrap_cnt_zero", cnt_w, 32'h0);
      rd_w = 5'd25; wdata_w = 32'h33;
      tick();
      we_w = 1'b0; rs1_w = 5'd4; rs2_w = 5'd9; dbg_w = 5'd25; #1;
      chk("wrap_x4", rs1_dw, 32'h11);
      chk("wrap_x9", rs2_dw, 32'h22);
      chk("oor_dbg", dbg_dw, 32'h0);
      chk("oor_cnt", cnt_w, 32'h0);
      chk("oor_dirty", 32'(dirty_w), 32'h0000_0210);
      rs1_w = 5'd25; rs2_w = 5'd31; dbg_w = 5'd19; #1;
      chk("oor_rs1", rs1_dw, 32'h0);
      chk("oor_rs2", rs2_dw, 32'h0);
      chk("x19_unwritten", dbg_dw, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
